// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus between the arbiter (slave) and its environment (master).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Handshake: a requester raises reqN with weN/addrN/wdataN and holds all of
  // them until ackN pulses for one cycle; it must drop reqN in the cycle after
  // ackN. The memory holds mem_ready high once the current access is done.
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;
  logic              busy;
  logic              err;
  state_t            state;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_read_data, mem_ready,
    output ack0, ack1, rdata0, rdata1,
    output mem_write, mem_address, mem_write_data, busy, err, state
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_read_data, mem_ready,
    input  ack0, ack1, rdata0, rdata1,
    input  mem_write, mem_address, mem_write_data, busy, err, state
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin pick: on contention the port that did not win last time wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic gnt
);

  assign valid = req0 | req1;
  assign gnt   = (req0 && req1) ? ~last_grant : (req1 ? PORT_DATA : PORT_IF);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a fixed-latency memory with mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state;
  logic              gnt;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              pick_valid;
  logic              pick_gnt;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              done_ok;
  logic              done_tmo;

  rr_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .gnt        (pick_gnt)
  );

  assign pick_we    = (pick_gnt == PORT_DATA) ? bus.we1    : bus.we0;
  assign pick_addr  = (pick_gnt == PORT_DATA) ? bus.addr1  : bus.addr0;
  assign pick_wdata = (pick_gnt == PORT_DATA) ? bus.wdata1 : bus.wdata0;

  // A ready seen in the first ACCESS cycle belongs to the previous access.
  assign done_ok  = bus.mem_ready && (cnt != '0);
  assign done_tmo = !bus.mem_ready && (cnt == CNT_MAX);

  assign bus.state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      gnt                <= PORT_IF;
      last_grant         <= PORT_DATA;
      cnt                <= '0;
      bus.ack0           <= 1'b0;
      bus.ack1           <= 1'b0;
      bus.rdata0         <= '0;
      bus.rdata1         <= '0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.busy           <= 1'b0;
      bus.err            <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt                <= pick_gnt;
            last_grant         <= pick_gnt;
            cnt                <= '0;
            bus.mem_address    <= pick_addr;
            bus.mem_write_data <= pick_wdata;
            bus.mem_write      <= pick_we;
            bus.busy           <= 1'b1;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (done_ok || done_tmo) begin
            state         <= RESP;
            bus.mem_write <= 1'b0;
            if (gnt == PORT_DATA) bus.ack1 <= 1'b1;
            else                  bus.ack0 <= 1'b1;
            if (done_tmo) begin
              bus.err <= 1'b1;
              if (gnt == PORT_DATA) bus.rdata1 <= '0;
              else                  bus.rdata0 <= '0;
            end else if (!bus.mem_write) begin
              if (gnt == PORT_DATA) bus.rdata1 <= bus.mem_read_data;
              else                  bus.rdata0 <= bus.mem_read_data;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared multi-cycle data memory (DataMemory, fixed-latency, mem_ready handshake).
- Port 0 is the instruction-fetch requester and port 1 the load/store requester of the MIPS core.
- Grants one requester at a time (round-robin), holds memory address, data and write stable until mem_ready, returns read data and a one-cycle ack.
- Flags a timeout if the memory never answers.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, cycles in ACCESS without mem_ready before abort (must exceed memory delay + 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  access request, held high until ack
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  ADDR_W each  byte address
- wdata0, wdata1  in  DATA_W each  write data
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata0, rdata1  out  DATA_W each  read result, valid with ack, held until that port's next ack
- mem_write  out  1  to memory mem_write
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory write_data
- mem_read_data  in  DATA_W  from memory read_data
- mem_ready  in  1  from memory mem_ready
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state, mid-access included):
  - state=IDLE, all outputs 0, cnt=0, last_grant=1 (port 0 wins first contest).
  - No ack is issued for an aborted access.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE; mem_write=0; mem_address/mem_write_data hold last values.
  - Only one req: grant it.
  - Both req: grant the port not equal to last_grant.
  - On grant edge: latch addr/we/wdata into registers, set gnt and last_grant, cnt=0, go to ACCESS.
- ACCESS:
  - mem_address, mem_write_data, mem_write come from the latched registers and are stable for the whole state. Requester inputs are ignored after the grant edge.
  - cnt increments every cycle, saturating at TIMEOUT.
  - mem_ready is ignored while cnt==0 (stale ready from a previous access).
  - mem_ready=1 with cnt>=1: capture mem_read_data into rdata[gnt] (reads only; writes leave rdata unchanged), go to RESP.
  - cnt==TIMEOUT with no ready: set err=1, rdata[gnt]=0, go to RESP.
  - Ready and timeout in the same cycle: ready wins, no err.
- RESP:
  - ack[gnt]=1 for exactly this cycle; mem_write=0; go to IDLE.
  - A requester must drop req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Latency: grant at edge k; a memory with delay D raises ready after edge k+D; ready is sampled at edge k+D+1; ack is high between edges k+D+1 and k+D+2. Minimum gap between grants is D+3 cycles.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- Write with both ports on the same address: ordered purely by grant order, no merging or forwarding.
- err clears only on reset. The arbiter continues serving requests after err is set.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - PORT_IF=0, PORT_DATA=1 constants
  - default widths
- Sub-module rr_pick: combinational 2-way round-robin grant from req0, req1, last_grant; outputs valid and gnt. Used so the fairness rule is unit-testable on its own.
- Top level contains the FSM, latches, counter and output registers.

Test Plan (bench pairs the arbiter with DataMemory, delay 3; k = grant edge):
- Single read: preload mem[64]=45, req1=1, we1=0, addr1=64 -> ack1 high between edges k+4 and k+5, rdata1=45, ack0 never high.
- Write then read: port 1 writes 100 to 128, then reads 128 -> first ack1 with mem_write high exactly for the ACCESS cycles; second ack1 returns rdata1=100.
- Contention from reset: req0 and req1 raised on the same cycle and held across re-requests -> grant order 0,1,0,1; each ack separated by 6 cycles; busy stays high except one IDLE cycle per access.
- Timeout: memory model with mem_ready tied 0, req0 read -> ack0 after TIMEOUT+1 cycles in ACCESS, rdata0=0, err=1 and stays 1; a following access to a working memory completes normally.
- Reset mid-ACCESS: rst_n pulsed low at cnt=2 of a port 0 read -> outputs immediately 0, state IDLE, no ack0; next contention grants port 0 first.
- Stale ready: two back-to-back reads of address 64 from port 0 -> second access still spends at least 2 cycles in ACCESS; both return 45.
